// File: rtl/lab4_sys_mem_arbiter.sv
// Two-to-one refill arbiter: round-robin merge of icache/dcache memory requests
// with in-order steering of memory responses through a FIFO of requester IDs.

package lab4_sys_mem_pkg;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   msg_type;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

endpackage

module lab4_sys_mem_arbiter
  import lab4_sys_mem_pkg::*;
#(
  parameter int p_num_outstanding = 4
) (
  input  logic          clk,
  input  logic          reset,

  input  mem_req_16B_t  in0_reqstream_msg,
  input  logic          in0_reqstream_val,
  output logic          in0_reqstream_rdy,

  input  mem_req_16B_t  in1_reqstream_msg,
  input  logic          in1_reqstream_val,
  output logic          in1_reqstream_rdy,

  output mem_resp_16B_t in0_respstream_msg,
  output logic          in0_respstream_val,
  input  logic          in0_respstream_rdy,

  output mem_resp_16B_t in1_respstream_msg,
  output logic          in1_respstream_val,
  input  logic          in1_respstream_rdy,

  output mem_req_16B_t  mem_reqstream_msg,
  output logic          mem_reqstream_val,
  input  logic          mem_reqstream_rdy,

  input  mem_resp_16B_t mem_respstream_msg,
  input  logic          mem_respstream_val,
  output logic          mem_respstream_rdy
);

  localparam int PtrW = (p_num_outstanding > 1) ? $clog2(p_num_outstanding) : 1;
  localparam int CntW = $clog2(p_num_outstanding + 1);

  logic                         prio_q, prio_d;
  logic [p_num_outstanding-1:0] id_fifo_q, id_fifo_d;
  logic [PtrW-1:0]              head_q, head_d;
  logic [PtrW-1:0]              tail_q, tail_d;
  logic [CntW-1:0]              count_q, count_d;

  logic grant0, grant1, grant_id;
  logic full, empty;
  logic head_id;
  logic push, pop;

  // Grant looks only at the valids and prio, never at any ready, so the
  // arbiter cannot form a combinational loop with the memory handshake.
  always_comb begin
    grant0   = in0_reqstream_val & (~in1_reqstream_val | ~prio_q);
    grant1   = in1_reqstream_val & (~in0_reqstream_val |  prio_q);
    grant_id = grant1;

    full  = (count_q == CntW'(p_num_outstanding));
    empty = (count_q == '0);

    mem_reqstream_val = (in0_reqstream_val | in1_reqstream_val) & ~full & ~reset;
    mem_reqstream_msg = grant_id ? in1_reqstream_msg : in0_reqstream_msg;
    in0_reqstream_rdy = grant0 & mem_reqstream_rdy & ~full & ~reset;
    in1_reqstream_rdy = grant1 & mem_reqstream_rdy & ~full & ~reset;

    push = mem_reqstream_val & mem_reqstream_rdy;
  end

  // Responses return in request order, so the FIFO head names the destination.
  always_comb begin
    head_id = id_fifo_q[head_q];

    in0_respstream_msg = mem_respstream_msg;
    in1_respstream_msg = mem_respstream_msg;
    in0_respstream_val = mem_respstream_val & ~empty & ~reset & ~head_id;
    in1_respstream_val = mem_respstream_val & ~empty & ~reset &  head_id;

    mem_respstream_rdy = ~empty & ~reset &
                         (head_id ? in1_respstream_rdy : in0_respstream_rdy);

    pop = mem_respstream_val & mem_respstream_rdy;
  end

  always_comb begin
    prio_d    = prio_q;
    id_fifo_d = id_fifo_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (push) begin
      id_fifo_d[tail_q] = grant_id;
      tail_d            = tail_q + PtrW'(1);
      prio_d            = ~grant_id;
    end

    if (pop) begin
      head_d = head_q + PtrW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q    <= 1'b0;
      id_fifo_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      prio_q    <= prio_d;
      id_fifo_q <= id_fifo_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_lab4_sys_mem_arbiter.sv
// Directed self-checking bench for lab4_sys_mem_arbiter: reset, routing, contention,
// outstanding limit, head-of-line stall, simultaneous push/pop and mid-stream reset.

module tb_lab4_sys_mem_arbiter;
  import lab4_sys_mem_pkg::*;

  logic          clk;
  logic          reset;
  mem_req_16B_t  in0_reqstream_msg, in1_reqstream_msg, mem_reqstream_msg;
  logic          in0_reqstream_val, in0_reqstream_rdy;
  logic          in1_reqstream_val, in1_reqstream_rdy;
  mem_resp_16B_t in0_respstream_msg, in1_respstream_msg, mem_respstream_msg;
  logic          in0_respstream_val, in0_respstream_rdy;
  logic          in1_respstream_val, in1_respstream_rdy;
  logic          mem_reqstream_val, mem_reqstream_rdy;
  logic          mem_respstream_val, mem_respstream_rdy;

  int testCount = 0;
  int failCount = 0;

  lab4_sys_mem_arbiter #(.p_num_outstanding(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .in0_reqstream_msg  (in0_reqstream_msg),
    .in0_reqstream_val  (in0_reqstream_val),
    .in0_reqstream_rdy  (in0_reqstream_rdy),
    .in1_reqstream_msg  (in1_reqstream_msg),
    .in1_reqstream_val  (in1_reqstream_val),
    .in1_reqstream_rdy  (in1_reqstream_rdy),
    .in0_respstream_msg (in0_respstream_msg),
    .in0_respstream_val (in0_respstream_val),
    .in0_respstream_rdy (in0_respstream_rdy),
    .in1_respstream_msg (in1_respstream_msg),
    .in1_respstream_val (in1_respstream_val),
    .in1_respstream_rdy (in1_respstream_rdy),
    .mem_reqstream_msg  (mem_reqstream_msg),
    .mem_reqstream_val  (mem_reqstream_val),
    .mem_reqstream_rdy  (mem_reqstream_rdy),
    .mem_respstream_msg (mem_respstream_msg),
    .mem_respstream_val (mem_respstream_val),
    .mem_respstream_rdy (mem_respstream_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mem_req_16B_t mkReq(input logic [2:0] t, input logic [7:0] op,
                                         input logic [31:0] addr, input logic [127:0] data);
    mem_req_16B_t m;
    m.msg_type = t;
    m.opaque   = op;
    m.addr     = addr;
    m.len      = 4'd0;
    m.data     = data;
    return m;
  endfunction

  function automatic mem_resp_16B_t mkResp(input logic [7:0] op, input logic [127:0] data);
    mem_resp_16B_t m;
    m.msg_type = MEM_TYPE_READ;
    m.opaque   = op;
    m.test     = 2'd0;
    m.len      = 4'd0;
    m.data     = data;
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    in0_reqstream_val  = 1'b0;
    in1_reqstream_val  = 1'b0;
    in0_reqstream_msg  = '0;
    in1_reqstream_msg  = '0;
    mem_reqstream_rdy  = 1'b1;
    mem_respstream_val = 1'b0;
    mem_respstream_msg = '0;
    in0_respstream_rdy = 1'b1;
    in1_respstream_rdy = 1'b1;
  endtask

  task automatic doReset();
    clearInputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in0_reqstream_val  = 1'b1;
    in1_reqstream_val  = 1'b1;
    mem_reqstream_rdy  = 1'b1;
    mem_respstream_val = 1'b1;
    in0_respstream_rdy = 1'b1;
    in1_respstream_rdy = 1'b1;
    tick();
    #1;
    testCount++; if (mem_reqstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mem_req_val: got %b want 0", mem_reqstream_val); end
    testCount++; if (in0_reqstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in0_req_rdy: got %b want 0", in0_reqstream_rdy); end
    testCount++; if (in1_reqstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in1_req_rdy: got %b want 0", in1_reqstream_rdy); end
    testCount++; if (in0_respstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in0_resp_val: got %b want 0", in0_respstream_val); end
    testCount++; if (in1_respstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL reset_in1_resp_val: got %b want 0", in1_respstream_val); end
    testCount++; if (mem_respstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mem_resp_rdy: got %b want 0", mem_respstream_rdy); end
    clearInputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    mem_req_16B_t  req;
    mem_resp_16B_t resp;
    doReset();
    req = mkReq(MEM_TYPE_READ, 8'h05, 32'h0000_1000, 128'h0);
    in0_reqstream_msg = req;
    in0_reqstream_val = 1'b1;
    #1;
    testCount++; if (mem_reqstream_val !== 1'b1) begin failCount++; $display("[TB] FAIL single_mem_req_val: got %b want 1", mem_reqstream_val); end
    testCount++; if (mem_reqstream_msg !== req) begin failCount++; $display("[TB] FAIL single_mem_req_msg: got %h want %h", mem_reqstream_msg, req); end
    testCount++; if (in0_reqstream_rdy !== 1'b1) begin failCount++; $display("[TB] FAIL single_in0_req_rdy: got %b want 1", in0_reqstream_rdy); end
    testCount++; if (in1_reqstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL single_in1_req_rdy: got %b want 0", in1_reqstream_rdy); end
    tick();
    in0_reqstream_val  = 1'b0;
    resp = mkResp(8'h05, {96'h0, 32'hdead_beef});
    mem_respstream_msg = resp;
    mem_respstream_val = 1'b1;
    #1;
    testCount++; if (in0_respstream_val !== 1'b1) begin failCount++; $display("[TB] FAIL single_in0_resp_val: got %b want 1", in0_respstream_val); end
    testCount++; if (in1_respstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL single_in1_resp_val: got %b want 0", in1_respstream_val); end
    testCount++; if (in0_respstream_msg !== resp) begin failCount++; $display("[TB] FAIL single_in0_resp_msg: got %h want %h", in0_respstream_msg, resp); end
    testCount++; if (mem_respstream_rdy !== 1'b1) begin failCount++; $display("[TB] FAIL single_mem_resp_rdy: got %b want 1", mem_respstream_rdy); end
    tick();
    // a stray response with nothing outstanding must be held off
    #1;
    testCount++; if (mem_respstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL stray_mem_resp_rdy: got %b want 0", mem_respstream_rdy); end
    testCount++; if (in0_respstream_val !== 1'b0 || in1_respstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL stray_resp_val: got %b%b want 00", in0_respstream_val, in1_respstream_val); end
    mem_respstream_val = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int expGrant[4] = '{0, 1, 0, 1};
    mem_req_16B_t expMsg;
    doReset();
    for (int i = 0; i < 4; i++) begin
      in0_reqstream_msg = mkReq(MEM_TYPE_READ,  8'h10 + 8'(i), 32'h2000 + 32'(i * 16), 128'h0);
      in1_reqstream_msg = mkReq(MEM_TYPE_WRITE, 8'h20 + 8'(i), 32'h3000 + 32'(i * 16), 128'(i + 7));
      in0_reqstream_val = 1'b1;
      in1_reqstream_val = 1'b1;
      #1;
      expMsg = (expGrant[i] == 1) ? in1_reqstream_msg : in0_reqstream_msg;
      testCount++; if (in0_reqstream_rdy !== (expGrant[i] == 0) || in1_reqstream_rdy !== (expGrant[i] == 1)) begin
        failCount++; $display("[TB] FAIL contention_grant[%0d]: got rdy0=%b rdy1=%b want grant %0d", i, in0_reqstream_rdy, in1_reqstream_rdy, expGrant[i]); end
      testCount++; if (mem_reqstream_msg !== expMsg) begin failCount++; $display("[TB] FAIL contention_msg[%0d]: got %h want %h", i, mem_reqstream_msg, expMsg); end
      tick();
    end
    in0_reqstream_val = 1'b0;
    in1_reqstream_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_respstream_msg = mkResp(8'h40 + 8'(i), 128'(i));
      mem_respstream_val = 1'b1;
      #1;
      testCount++; if (in0_respstream_val !== (expGrant[i] == 0) || in1_respstream_val !== (expGrant[i] == 1)) begin
        failCount++; $display("[TB] FAIL contention_route[%0d]: got val0=%b val1=%b want dest %0d", i, in0_respstream_val, in1_respstream_val, expGrant[i]); end
      tick();
    end
    mem_respstream_val = 1'b0;
  endtask

  task automatic test_outstanding_limit();
    int expDest[4] = '{0, 0, 0, 1};
    doReset();
    in0_reqstream_msg = mkReq(MEM_TYPE_READ,  8'h51, 32'h4000, 128'h0);
    in1_reqstream_msg = mkReq(MEM_TYPE_WRITE, 8'h52, 32'h5000, 128'h1);
    in0_reqstream_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      testCount++; if (mem_reqstream_val !== 1'b1 || in0_reqstream_rdy !== 1'b1) begin
        failCount++; $display("[TB] FAIL limit_accept[%0d]: got val=%b rdy0=%b want 1 1", i, mem_reqstream_val, in0_reqstream_rdy); end
      tick();
    end
    in1_reqstream_val = 1'b1;
    #1;
    testCount++; if (mem_reqstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL limit_full_val: got %b want 0", mem_reqstream_val); end
    testCount++; if (in0_reqstream_rdy !== 1'b0 || in1_reqstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL limit_full_rdy: got %b%b want 00", in0_reqstream_rdy, in1_reqstream_rdy); end
    tick();
    mem_respstream_val = 1'b1;
    #1;
    testCount++; if (mem_respstream_rdy !== 1'b1 || in0_respstream_val !== 1'b1) begin failCount++; $display("[TB] FAIL limit_pop: got rdy=%b val0=%b want 1 1", mem_respstream_rdy, in0_respstream_val); end
    testCount++; if (mem_reqstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL limit_no_bypass: got %b want 0", mem_reqstream_val); end
    tick();
    mem_respstream_val = 1'b0;
    #1;
    testCount++; if (mem_reqstream_val !== 1'b1 || in1_reqstream_rdy !== 1'b1 || in0_reqstream_rdy !== 1'b0) begin
      failCount++; $display("[TB] FAIL limit_next_accept: got val=%b rdy0=%b rdy1=%b want 1 0 1", mem_reqstream_val, in0_reqstream_rdy, in1_reqstream_rdy); end
    tick();
    in0_reqstream_val = 1'b0;
    in1_reqstream_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_respstream_val = 1'b1;
      #1;
      testCount++; if (in0_respstream_val !== (expDest[i] == 0) || in1_respstream_val !== (expDest[i] == 1)) begin
        failCount++; $display("[TB] FAIL limit_drain[%0d]: got val0=%b val1=%b want dest %0d", i, in0_respstream_val, in1_respstream_val, expDest[i]); end
      tick();
    end
    mem_respstream_val = 1'b0;
  endtask

  task automatic test_hol_stall();
    doReset();
    in1_reqstream_msg = mkReq(MEM_TYPE_READ, 8'h61, 32'h6000, 128'h0);
    in1_reqstream_val = 1'b1;
    tick();
    in1_reqstream_val = 1'b0;
    in0_reqstream_msg = mkReq(MEM_TYPE_READ, 8'h62, 32'h7000, 128'h0);
    in0_reqstream_val = 1'b1;
    tick();
    in0_reqstream_val  = 1'b0;
    mem_respstream_val = 1'b1;
    in1_respstream_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      testCount++; if (mem_respstream_rdy !== 1'b0 || in0_respstream_val !== 1'b0) begin
        failCount++; $display("[TB] FAIL hol_stall[%0d]: got rdy=%b val0=%b want 0 0", i, mem_respstream_rdy, in0_respstream_val); end
      tick();
    end
    in1_respstream_rdy = 1'b1;
    #1;
    testCount++; if (in1_respstream_val !== 1'b1 || mem_respstream_rdy !== 1'b1 || in0_respstream_val !== 1'b0) begin
      failCount++; $display("[TB] FAIL hol_drain1: got val1=%b rdy=%b val0=%b want 1 1 0", in1_respstream_val, mem_respstream_rdy, in0_respstream_val); end
    tick();
    #1;
    testCount++; if (in0_respstream_val !== 1'b1 || mem_respstream_rdy !== 1'b1 || in1_respstream_val !== 1'b0) begin
      failCount++; $display("[TB] FAIL hol_drain0: got val0=%b rdy=%b val1=%b want 1 1 0", in0_respstream_val, mem_respstream_rdy, in1_respstream_val); end
    tick();
    #1;
    testCount++; if (mem_respstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL hol_empty: got %b want 0", mem_respstream_rdy); end
    mem_respstream_val = 1'b0;
    tick();
  endtask

  task automatic test_push_pop();
    logic pushIds[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic idQueue[$];
    logic expHead;
    doReset();
    in0_reqstream_msg = mkReq(MEM_TYPE_READ,  8'h71, 32'h8000, 128'h0);
    in1_reqstream_msg = mkReq(MEM_TYPE_WRITE, 8'h72, 32'h9000, 128'h3);
    in0_reqstream_val = 1'b1;
    tick();
    idQueue.push_back(1'b0);
    in0_reqstream_val = 1'b0;
    in1_reqstream_val = 1'b1;
    tick();
    idQueue.push_back(1'b1);
    for (int k = 0; k < 8; k++) begin
      in0_reqstream_val  = ~pushIds[k];
      in1_reqstream_val  = pushIds[k];
      mem_respstream_val = 1'b1;
      #1;
      expHead = idQueue[0];
      testCount++; if (mem_reqstream_val !== 1'b1 || mem_respstream_rdy !== 1'b1) begin
        failCount++; $display("[TB] FAIL pushpop_handshake[%0d]: got reqval=%b resprdy=%b want 1 1", k, mem_reqstream_val, mem_respstream_rdy); end
      testCount++; if (in0_respstream_val !== ~expHead || in1_respstream_val !== expHead) begin
        failCount++; $display("[TB] FAIL pushpop_route[%0d]: got val0=%b val1=%b want dest %0d", k, in0_respstream_val, in1_respstream_val, expHead); end
      tick();
      void'(idQueue.pop_front());
      idQueue.push_back(pushIds[k]);
    end
    in1_reqstream_val  = 1'b0;
    mem_respstream_val = 1'b0;
    in0_reqstream_val  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      testCount++; if (mem_reqstream_val !== 1'b1) begin failCount++; $display("[TB] FAIL pushpop_fill[%0d]: got %b want 1", i, mem_reqstream_val); end
      tick();
      idQueue.push_back(1'b0);
    end
    #1;
    testCount++; if (mem_reqstream_val !== 1'b0) begin failCount++; $display("[TB] FAIL pushpop_full: got %b want 0", mem_reqstream_val); end
    in0_reqstream_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_respstream_val = 1'b1;
      #1;
      expHead = idQueue[0];
      testCount++; if (in0_respstream_val !== ~expHead || in1_respstream_val !== expHead) begin
        failCount++; $display("[TB] FAIL pushpop_drain[%0d]: got val0=%b val1=%b want dest %0d", i, in0_respstream_val, in1_respstream_val, expHead); end
      tick();
      void'(idQueue.pop_front());
    end
    #1;
    testCount++; if (mem_respstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL pushpop_empty: got %b want 0", mem_respstream_rdy); end
    mem_respstream_val = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    doReset();
    in0_reqstream_msg = mkReq(MEM_TYPE_READ,  8'h81, 32'hA000, 128'h0);
    in1_reqstream_msg = mkReq(MEM_TYPE_WRITE, 8'h82, 32'hB000, 128'h9);
    in0_reqstream_val = 1'b1;
    in1_reqstream_val = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    in0_reqstream_val = 1'b0;
    in1_reqstream_val = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    // both valid with memory stalled exposes the grant without accepting
    in0_reqstream_val = 1'b1;
    in1_reqstream_val = 1'b1;
    mem_reqstream_rdy = 1'b0;
    #1;
    testCount++; if (mem_reqstream_msg !== in0_reqstream_msg) begin failCount++; $display("[TB] FAIL midreset_prio: got %h want %h", mem_reqstream_msg, in0_reqstream_msg); end
    testCount++; if (mem_reqstream_val !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_not_full: got %b want 1", mem_reqstream_val); end
    tick();
    in0_reqstream_val = 1'b0;
    mem_reqstream_rdy = 1'b1;
    #1;
    testCount++; if (in1_reqstream_rdy !== 1'b1) begin failCount++; $display("[TB] FAIL midreset_in1_accept: got %b want 1", in1_reqstream_rdy); end
    tick();
    in1_reqstream_val  = 1'b0;
    mem_respstream_msg = mkResp(8'h82, 128'h55);
    mem_respstream_val = 1'b1;
    #1;
    testCount++; if (in1_respstream_val !== 1'b1 || in0_respstream_val !== 1'b0 || mem_respstream_rdy !== 1'b1) begin
      failCount++; $display("[TB] FAIL midreset_route: got val1=%b val0=%b rdy=%b want 1 0 1", in1_respstream_val, in0_respstream_val, mem_respstream_rdy); end
    tick();
    #1;
    testCount++; if (mem_respstream_rdy !== 1'b0) begin failCount++; $display("[TB] FAIL midreset_empty: got %b want 0", mem_respstream_rdy); end
    mem_respstream_val = 1'b0;
    tick();
  endtask

  initial begin
    clearInputs();
    reset = 1'b1;
    test_reset();
    test_single_read();
    test_contention();
    test_outstanding_limit();
    test_hol_stall();
    test_push_pop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
